// File: rtl/button_pkg.sv
// button_pkg: FSM encoding and default timing for the button pulse conditioner
package button_pkg;
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int REPEAT_DELAY_DEF    = 50000000;
    localparam int REPEAT_PERIOD_DEF   = 25000000;
    localparam int CNT_W_DEF           = 26;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous inputs, async reset to 0
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] m;
    always_ff @(posedge clk or posedge reset)
        if (reset) {q, m} <= '0;
        else {q, m} <= {m, d};
endmodule

// File: rtl/button_pulse_conditioner.sv
// button_pulse_conditioner: debounce a raw button into one-cycle press and auto-repeat pulses
module button_pulse_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    input  logic repeat_en,
    output logic btn_level,
    output logic btn_pulse
);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] R_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(REPEAT_PERIOD - 1);
    state_t state;
    logic s, rep_started;
    logic [CNT_W-1:0] dcnt, rcnt, thr;
    sync_2ff #(.W(1)) u_sync (.clk(clk), .reset(reset), .d(btn_in), .q(s));
    assign thr = rep_started ? P_LAST : R_LAST;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state       <= IDLE;
            dcnt        <= '0;
            rcnt        <= '0;
            rep_started <= 1'b0;
            btn_level   <= 1'b0;
            btn_pulse   <= 1'b0;
        end else begin
            btn_pulse <= 1'b0;
            case (state)
                IDLE:
                    if (s) begin
                        state <= PRESS_WAIT;
                        dcnt  <= '0;
                    end
                PRESS_WAIT:
                    if (!s) state <= IDLE;
                    else if (dcnt == D_LAST) begin
                        state       <= HELD;
                        btn_pulse   <= 1'b1;
                        btn_level   <= 1'b1;
                        rcnt        <= '0;
                        rep_started <= 1'b0;
                    end else dcnt <= dcnt + 1'b1;
                HELD:
                    if (!s) begin
                        state <= RELEASE_WAIT;
                        dcnt  <= '0;
                    end else if (!repeat_en) rcnt <= '0;
                    else if (rcnt == thr) begin
                        btn_pulse   <= 1'b1;
                        rcnt        <= '0;
                        rep_started <= 1'b1;
                    end else rcnt <= rcnt + 1'b1;
                RELEASE_WAIT:
                    // a bounce back high resumes holding without a new press pulse
                    if (s) begin
                        state <= HELD;
                        rcnt  <= '0;
                    end else if (dcnt == D_LAST) begin
                        state     <= IDLE;
                        btn_level <= 1'b0;
                    end else dcnt <= dcnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
endmodule

// File: doc/button_pulse_conditioner.md
# button_pulse_conditioner

Conditions the raw push-button input that advances the scrolling text on the four-digit LED driver. The block synchronises the asynchronous pad signal, debounces it, and emits a clean one-cycle `btn_pulse` per press plus optional auto-repeat pulses while the button is held. It sits directly upstream of the four-digit text/button LED driver: `btn_pulse` drives that driver's advance input (`btnr`) in place of the raw button.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz); legal range is 2 or more.
- `REPEAT_DELAY`, default 50000000: held cycles from the press pulse to the first repeat pulse.
- `REPEAT_PERIOD`, default 25000000: cycles between subsequent repeat pulses.
- `CNT_W`, default 26: counter width; must satisfy 2^CNT_W > max(all three counts above).
- `clk`, input, 1: single clock for the whole block; all state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-high; clears all state immediately.
- `btn_in`, input, 1: raw, bouncing, asynchronous button.
- `repeat_en`, input, 1: synchronous; when 1, holding the button generates repeat pulses.
- `btn_level`, output, 1: registered debounced button level.
- `btn_pulse`, output, 1: registered; high for exactly one cycle per accepted press and per repeat event.

## Operation
- **Synchroniser.** Two flip-flops, `btn_in` → `s1` → `s`. Only `s` feeds the FSM.
- **Debounce counter (`dcnt`).** Shared by PRESS_WAIT and RELEASE_WAIT. It is set to 0 on entry to either state.
- **Repeat counter (`rcnt`).** Used only in HELD. Flag `rep_started` selects the threshold: REPEAT_DELAY-1 before the first repeat, REPEAT_PERIOD-1 after it.
- **FSM states:** IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. The encoding is defined in the package.
- **IDLE** (`btn_level`=0).
  - `s`=1 → PRESS_WAIT.
- **PRESS_WAIT** (`btn_level`=0).
  - `s`=0 → IDLE. Bounce rejected, no pulse.
  - `s`=1 and `dcnt`<DEBOUNCE_CYCLES-1 → `dcnt`+1.
  - `s`=1 and `dcnt`=DEBOUNCE_CYCLES-1 → HELD. `btn_pulse` and `btn_level` are set on this edge; `rcnt`=0 and `rep_started`=0.
- **HELD** (`btn_level`=1).
  - `s`=0 → RELEASE_WAIT.
  - `repeat_en`=0 → `rcnt` held at 0, no pulses.
  - `repeat_en`=1 → `rcnt`+1 each cycle. When it reaches the active threshold: one-cycle `btn_pulse`, `rcnt`=0, `rep_started`=1.
- **RELEASE_WAIT** (`btn_level` stays 1).
  - `s`=1 → HELD with `rcnt`=0 and `rep_started` unchanged. Release bounce produces no pulse.
  - `s`=0 for DEBOUNCE_CYCLES cycles → IDLE; `btn_level` is cleared on that edge.
- **`repeat_en` dropped in HELD** → `rcnt` returns to 0 on the next edge. When it is re-asserted, counting restarts from 0 against the current threshold.
- **Saturation.** `rcnt` and `dcnt` never wrap; their thresholds always terminate them first.
- **Pulse spacing.** `btn_pulse` is never high on two consecutive cycles.

## Timing
- **Reset values.** `btn_level`=0, `btn_pulse`=0, state=IDLE, `s1`=`s`=0, all counters 0, `rep_started`=0.
- **Reset mid-operation.** Outputs drop asynchronously. After release, a still-held button must be re-debounced from IDLE before any pulse.
- **Press latency.** `btn_in` rises before edge 1 and stays high. `s` is high after edge 2; state is PRESS_WAIT after edge 3. `btn_pulse` and `btn_level` go high after edge DEBOUNCE_CYCLES+3, and `btn_pulse` falls after the next edge.
- **Release latency.** `btn_level` falls DEBOUNCE_CYCLES+3 edges after `btn_in` falls and stays low.
- **Repeat spacing.**
  - First repeat pulse: REPEAT_DELAY cycles after the press pulse.
  - Later repeats: every REPEAT_PERIOD cycles.
- **Glitch rejection.** Any low glitch in PRESS_WAIT restarts the debounce from IDLE.

## Structure
- **Package `button_pkg`:** FSM state localparams (2-bit), and default values for DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD and CNT_W.
- **Sub-module `sync_2ff`:** generic 2-flop synchroniser with asynchronous active-high reset to 0. It is reusable for the driver's other asynchronous inputs.
- **Top level:** FSM, the two counters and the output registers.

## Test plan
All scenarios use a 10 ns clock and the overrides DEBOUNCE_CYCLES=8, REPEAT_DELAY=40, REPEAT_PERIOD=16.
1. **Clean press.** `btn_in` 0→1 held 200 cycles, `repeat_en`=0 → exactly one `btn_pulse`, after edge 11. `btn_level`=1 from edge 11 until 11 edges after release.
2. **Bounce.** `btn_in` toggles every 3 cycles for 30 cycles, then stays high → no pulse during toggling. One pulse 11 edges after the final rise; release bounce of 2-cycle glitches produces no extra pulse.
3. **Auto-repeat.** `repeat_en`=1, press held 120 cycles → pulses at edges 11, 51, 67, 83, 99, 115, and none after release.
4. **Short glitch.** A 5-cycle high pulse on `btn_in` → `btn_pulse` and `btn_level` stay 0 throughout.
5. **Reset mid-hold.** Reset asserted at edge 30 of a held press, for 3 cycles → outputs 0 immediately. A new pulse appears 11 edges after reset release while the button stays held.
6. **End-to-end.** Instantiate with the four-digit text/button LED driver using the driver bench's stimulus (reset 100–3100 ns, button held 4000 ns) → the displayed text advances exactly once per accepted press.
